// File: rtl/cordic_sched.sv
// Round-robin scheduler and sequencer that shares one cordic_data datapath
// among N_REQ requesters: arbitrate, load, BIT_WIDTH rotations, then present the result.
module cordic_sched #(
  parameter int BIT_WIDTH   = 16,
  parameter int N_REQ       = 4,
  parameter int LOG_2_N_REQ = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*BIT_WIDTH-1:0] req_angle,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [LOG_2_N_REQ-1:0]     res_id,
  output logic [BIT_WIDTH-1:0]       res_x,
  output logic [BIT_WIDTH-1:0]       res_y,
  output logic                       busy,
  output logic                       dp_add,
  output logic                       dp_sub,
  output logic                       dp_iter,
  output logic                       dp_load_regs,
  output logic [BIT_WIDTH-1:0]       dp_target,
  input  logic                       dp_reached_target,
  input  logic                       dp_dir,
  input  logic [BIT_WIDTH-1:0]       dp_x,
  input  logic [BIT_WIDTH-1:0]       dp_y
);

  typedef enum logic [1:0] {IDLE, LOAD, ROTATE, RESULT} state_t;

  state_t                   state;
  logic [BIT_WIDTH-1:0]     angle;
  logic [LOG_2_N_REQ-1:0]   id;
  logic [LOG_2_N_REQ-1:0]   last_grant;

  logic                     found;
  logic [LOG_2_N_REQ-1:0]   grant_id;
  logic [LOG_2_N_REQ-1:0]   cand;
  logic [N_REQ-1:0]         grant_vec;
  int unsigned              idx;

  // Search starts just after the previous winner and wraps modulo N_REQ.
  always_comb begin
    found     = 1'b0;
    grant_id  = '0;
    grant_vec = '0;
    idx       = 0;
    cand      = '0;
    for (int unsigned off = 1; off <= N_REQ; off++) begin
      idx  = (32'(last_grant) + off) % N_REQ;
      cand = LOG_2_N_REQ'(idx);
      if (!found && req_valid[cand]) begin
        found           = 1'b1;
        grant_id        = cand;
        grant_vec[cand] = 1'b1;
      end
    end
  end

  // Controls are decoded from the state register only, so an asynchronous
  // reset clears them immediately; rst_n also masks the combinational grant.
  always_comb begin
    busy         = (state != IDLE);
    req_ready    = (state == IDLE && rst_n) ? grant_vec : '0;
    dp_load_regs = (state == LOAD);
    dp_add       = (state == ROTATE) &&  dp_dir;
    dp_sub       = (state == ROTATE) && !dp_dir;
    dp_iter      = (state == ROTATE) && !dp_reached_target;
    dp_target    = angle;
    res_valid    = (state == RESULT);
    res_id       = res_valid ? id   : '0;
    res_x        = res_valid ? dp_x : '0;
    res_y        = res_valid ? dp_y : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      angle      <= '0;
      id         <= '0;
      last_grant <= LOG_2_N_REQ'(N_REQ - 1);
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            angle      <= req_angle[grant_id*BIT_WIDTH +: BIT_WIDTH];
            id         <= grant_id;
            last_grant <= grant_id;
            state      <= LOAD;
          end
        end
        LOAD:    state <= ROTATE;
        ROTATE:  if (dp_reached_target) state <= RESULT;
        RESULT:  if (res_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_sched.sv
// Self-checking bench for cordic_sched with a behavioural datapath stub,
// a round-robin reference model and a transaction-level result model.
`timescale 1ns/1ps
module tb_cordic_sched;

  localparam int BW = 16;
  localparam int NR = 4;
  localparam int LN = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req_valid;
  logic [NR*BW-1:0]  req_angle;
  logic [NR-1:0]     req_ready;
  logic              res_valid;
  logic              res_ready;
  logic [LN-1:0]     res_id;
  logic [BW-1:0]     res_x, res_y;
  logic              busy;
  logic              dp_add, dp_sub, dp_iter, dp_load_regs;
  logic [BW-1:0]     dp_target;
  logic              dp_reached_target, dp_dir;
  logic [BW-1:0]     dp_x, dp_y;

  cordic_sched #(.BIT_WIDTH(BW), .N_REQ(NR), .LOG_2_N_REQ(LN)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_angle(req_angle),
    .req_ready(req_ready), .res_valid(res_valid), .res_ready(res_ready),
    .res_id(res_id), .res_x(res_x), .res_y(res_y), .busy(busy),
    .dp_add(dp_add), .dp_sub(dp_sub), .dp_iter(dp_iter),
    .dp_load_regs(dp_load_regs), .dp_target(dp_target),
    .dp_reached_target(dp_reached_target), .dp_dir(dp_dir),
    .dp_x(dp_x), .dp_y(dp_y)
  );

  always #5 clk = ~clk;

  // Datapath stub: shift-add rotation driven only by the DUT's controls.
  logic signed [BW-1:0] sx = '0, sy = '0, sz = '0;
  logic [3:0]           si = '0;
  assign dp_x = sx;
  assign dp_y = sy;
  assign dp_dir = ~sz[BW-1];
  assign dp_reached_target = (si == 4'd15);

  always @(posedge clk) begin
    if (dp_load_regs) begin
      sx <= 16'sh4DBA; sy <= '0; sz <= dp_target; si <= '0;
    end else if (dp_add) begin
      sx <= sx - (sy >>> si); sy <= sy + (sx >>> si); sz <= sz - (16'sh2000 >>> si);
      if (dp_iter) si <= si + 4'd1;
    end else if (dp_sub) begin
      sx <= sx + (sy >>> si); sy <= sy - (sx >>> si); sz <= sz + (16'sh2000 >>> si);
      if (dp_iter) si <= si + 4'd1;
    end
  end

  // Whole-transaction result: 16 greedy micro-rotations toward the angle.
  function automatic logic [31:0] ref_xy(input logic [BW-1:0] ang);
    logic signed [BW-1:0] x, y, z, t;
    x = 16'sh4DBA; y = '0; z = ang;
    for (int i = 0; i < BW; i++) begin
      t = x;
      if (!z[BW-1]) begin
        x = x - (y >>> i); y = y + (t >>> i); z = z - (16'sh2000 >>> i);
      end else begin
        x = x + (y >>> i); y = y - (t >>> i); z = z + (16'sh2000 >>> i);
      end
    end
    return {x, y};
  endfunction

  function automatic int pick(input logic [NR-1:0] m, input int last);
    for (int off = 1; off <= NR; off++)
      if (m[(last + off) % NR]) return (last + off) % NR;
    return -1;
  endfunction

  int checks = 0;
  int errors = 0;
  int last_model = NR - 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Protocol monitor, sampled mid-cycle.
  int rot_total = 0, iter_total = 0, load_total = 0, proto_errs = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (dp_add || dp_sub) rot_total++;
      if (dp_iter) iter_total++;
      if (dp_load_regs) load_total++;
      if ($countones(req_ready) > 1) begin proto_errs++; $display("FAIL onehot: req_ready=%b", req_ready); end
      if (dp_add && dp_sub) begin proto_errs++; $display("FAIL addsub: both high"); end
      if (dp_load_regs && (dp_add || dp_sub || dp_iter)) begin proto_errs++; $display("FAIL load_iso: other controls with load"); end
      if ((dp_add || dp_sub) && (dp_add !== dp_dir)) begin proto_errs++; $display("FAIL dir: add=%b dir=%b", dp_add, dp_dir); end
      if ((dp_add || dp_sub) && (dp_iter !== !dp_reached_target)) begin proto_errs++; $display("FAIL iter: iter=%b reached=%b", dp_iter, dp_reached_target); end
      if (busy && req_ready != 0) begin proto_errs++; $display("FAIL busy_grant: req_ready=%b while busy", req_ready); end
    end
  end

  task automatic run_txn(input logic [NR-1:0] mask, input int exp_id, input int hold, output time t_acc);
    logic [BW-1:0] ang [NR];
    logic [31:0]   exy;
    logic [63:0]   held;
    int r0, i0, l0, k, exp;
    bit got;
    exp = (exp_id >= 0) ? exp_id : pick(mask, last_model);
    for (int j = 0; j < NR; j++) begin
      ang[j] = BW'($urandom);
      req_angle[j*BW +: BW] = ang[j];
    end
    req_valid = mask;
    got = 0;
    t_acc = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (req_ready != 0) got = 1;
    end
    chk("grant_seen", 64'(got), 64'd1);
    if (!got) begin req_valid = '0; return; end
    chk("req_ready", 64'(req_ready), 64'd1 << exp);
    r0 = rot_total; i0 = iter_total; l0 = load_total;
    @(posedge clk);
    t_acc = $time;
    #1;
    req_valid = '0;
    res_ready = (hold == 0);
    last_model = exp;
    exy = ref_xy(ang[exp]);
    chk("busy_after_accept", 64'(busy), 64'd1);
    k = 0;
    while (k < 40) begin
      @(posedge clk); #1; k++;
      if (res_valid) break;
    end
    chk("latency", 64'(k), 64'(BW + 1));
    chk("res_id", 64'(res_id), 64'(exp));
    chk("res_xy", {32'd0, res_x, res_y}, {32'd0, exy});
    chk("rotations", 64'(rot_total - r0), 64'(BW));
    chk("iters", 64'(iter_total - i0), 64'(BW - 1));
    chk("loads", 64'(load_total - l0), 64'd1);
    if (hold > 0) begin
      held = {30'd0, res_id, res_x, res_y};
      req_valid = ~(NR'(1) << exp);
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        chk("hold_valid", 64'(res_valid), 64'd1);
        chk("hold_data", {30'd0, res_id, res_x, res_y}, held);
        chk("hold_ready", 64'(req_ready), 64'd0);
        chk("hold_quiet", 64'(rot_total - r0 + load_total - l0), 64'(BW + 1));
      end
      res_ready = 1'b1;
    end
    @(posedge clk); #1;
    req_valid = '0;
    chk("idle_after_hs", 64'({busy, res_valid}), 64'd0);
    res_ready = 1'b1;
  endtask

  typedef struct {
    logic [NR-1:0] mask;
    int            exp_id;
    int            hold;
    bit            gap;
  } vec_t;

  vec_t tbl [14];
  time  t_now, t_prev;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = '{4'b1111, 0, 0, 1'b0};
    tbl[1]  = '{4'b1111, 1, 0, 1'b1};
    tbl[2]  = '{4'b1111, 2, 0, 1'b1};
    tbl[3]  = '{4'b1111, 3, 0, 1'b1};
    tbl[4]  = '{4'b1111, 0, 0, 1'b1};
    tbl[5]  = '{4'b1111, 1, 0, 1'b1};
    tbl[6]  = '{4'b1111, 2, 0, 1'b1};
    tbl[7]  = '{4'b1111, 3, 0, 1'b1};
    tbl[8]  = '{4'b0110, 1, 0, 1'b0};
    tbl[9]  = '{4'b0110, 2, 0, 1'b0};
    tbl[10] = '{4'b0100, 2, 0, 1'b0};
    tbl[11] = '{4'b1001, 3, 5, 1'b0};
    tbl[12] = '{4'b0011, 0, 0, 1'b0};
    tbl[13] = '{4'b1010, 1, 0, 1'b0};

    rst_n = 1'b0; req_valid = '0; req_angle = '0; res_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {req_ready, res_valid, res_id, res_x, res_y, busy,
                          dp_add, dp_sub, dp_iter, dp_load_regs, dp_target}, 64'd0);
    rst_n = 1'b1;

    t_prev = 0;
    for (int v = 0; v < 14; v++) begin
      run_txn(tbl[v].mask, tbl[v].exp_id, tbl[v].hold, t_now);
      if (tbl[v].gap) chk("rr_gap", 64'(t_now - t_prev), 64'((BW + 3) * 10));
      t_prev = t_now;
    end

    // Winner withdraws in its winning cycle: grant moves on the same cycle.
    req_valid = 4'b1100; #1;
    chk("pre_drop_grant", 64'(req_ready), 64'b0100);
    req_valid = 4'b1000; #1;
    chk("post_drop_grant", 64'(req_ready), 64'b1000);
    run_txn(4'b1000, 3, 0, t_now);

    for (int r = 0; r < 20; r++) begin
      logic [NR-1:0] m;
      m = NR'($urandom_range(1, 15));
      run_txn(m, -1, int'($urandom_range(0, 2)), t_now);
    end

    // Asynchronous reset in the 8th rotation cycle.
    req_valid = 4'b0100;
    @(negedge clk);
    @(posedge clk); #1;
    req_valid = '0;
    repeat (8) @(posedge clk);
    #2;
    chk("mid_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    req_valid = 4'b0101;
    #1;
    chk("async_reset_outputs", {req_ready, res_valid, res_id, res_x, res_y, busy,
                                dp_add, dp_sub, dp_iter, dp_load_regs, dp_target}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    last_model = NR - 1;
    run_txn(4'b0101, 0, 0, t_now);
    run_txn(4'b0100, 2, 0, t_now);

    chk("protocol", 64'(proto_errs), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
